// File: rtl/tipi_nib_sequencer.sv
// Pi-side nibble-protocol sequencer for the TIPI TD/TC/RD/RC latch bank.
// Optional mid-transfer abort counter enabled by defining TIPI_NIB_TIMEOUT_EN.
module tipi_nib_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       r_clk,
   input  logic       r_nibrst,
   input  logic [3:0] nib_in,
   output logic [3:0] nib_out,
   output logic       nib_oe,
   input  logic [7:0] td_q,
   input  logic [7:0] tc_q,
   input  logic [7:0] rd_q,
   input  logic [7:0] rc_q,
   output logic [7:0] wr_d,
   output logic       rd_we,
   output logic       rc_we,
   output logic       busy,
   output logic       err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2
   } state_t;

   // Pin nibbles carry the MSB on bit 0; internally values use normal [3:0] order.
   function automatic logic [3:0] f_rev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_rst_sync;
   logic [3:0]             r_nib_sync [SYNC_STAGES];
   logic                   r_clk_prev;

   logic       w_edge;
   logic       w_restart;
   logic [3:0] w_nib_val;
   logic       w_cmd_wr;
   logic [1:0] w_cmd_sel;
   logic       w_cmd_bad;
   logic [7:0] w_sel_q;
   logic       w_tmo_hit;

   state_t     r_state;
   logic       r_wr;
   logic [1:0] r_sel;
   logic       r_bad;
   logic [7:0] r_shadow;
   logic [3:0] r_hi;
   logic [3:0] r_nib_out;
   logic       r_nib_oe;
   logic [7:0] r_wr_d;
   logic       r_rd_we;
   logic       r_rc_we;
   logic       r_busy;
   logic       r_err;

   // Synchronizer chains for the asynchronous Pi pins plus edge history.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_sync <= '0;
         r_rst_sync <= '0;
         r_clk_prev <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_nib_sync[i] <= 4'd0;
         end
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], r_clk};
         r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], r_nibrst};
         r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
         r_nib_sync[0] <= nib_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_nib_sync[i] <= r_nib_sync[i-1];
         end
      end
   end

   assign w_edge    = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
   assign w_restart = r_rst_sync[SYNC_STAGES-1];
   assign w_nib_val = f_rev4(r_nib_sync[SYNC_STAGES-1]);
   assign w_cmd_wr  = w_nib_val[2];
   assign w_cmd_sel = w_nib_val[1:0];
   // Reserved bit set, or a write aimed at the TI-owned TD/TC latches.
   assign w_cmd_bad = w_nib_val[3] | (w_cmd_wr & ~w_cmd_sel[1]);

   // Latch source selection for the read snapshot.
   always_comb begin
      w_sel_q = 8'd0;
      case (w_cmd_sel)
         2'd0:    w_sel_q = td_q;
         2'd1:    w_sel_q = tc_q;
         2'd2:    w_sel_q = rd_q;
         2'd3:    w_sel_q = rc_q;
         default: w_sel_q = 8'd0;
      endcase
   end

`ifdef TIPI_NIB_TIMEOUT_EN
   logic [31:0] r_tmo_cnt;

   assign w_tmo_hit = (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Idle-cycle counter while a transfer is open; any strobe restarts it.
   always_ff @(posedge clk) begin
      if (reset || w_restart || w_edge || (r_state == ST_IDLE)) begin
         r_tmo_cnt <= 32'd0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + 32'd1;
      end
   end
`else
   assign w_tmo_hit = 1'b0;
`endif

   // Transfer FSM with registered pin/latch-side outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_wr      <= 1'b0;
         r_sel     <= 2'd0;
         r_bad     <= 1'b0;
         r_shadow  <= 8'd0;
         r_hi      <= 4'd0;
         r_nib_out <= 4'd0;
         r_nib_oe  <= 1'b0;
         r_wr_d    <= 8'd0;
         r_rd_we   <= 1'b0;
         r_rc_we   <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_rd_we <= 1'b0;
         r_rc_we <= 1'b0;
         r_err   <= 1'b0;
         if (w_restart) begin
            r_state   <= ST_IDLE;
            r_nib_out <= 4'd0;
            r_nib_oe  <= 1'b0;
            r_busy    <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_edge) begin
                     r_wr      <= w_cmd_wr;
                     r_sel     <= w_cmd_sel;
                     r_bad     <= w_cmd_bad;
                     r_shadow  <= w_sel_q;
                     r_err     <= w_cmd_bad;
                     r_busy    <= 1'b1;
                     r_state   <= ST_HI;
                     if (!w_cmd_wr && !w_cmd_bad) begin
                        r_nib_out <= f_rev4(w_sel_q[7:4]);
                        r_nib_oe  <= 1'b1;
                     end else begin
                        r_nib_out <= 4'd0;
                        r_nib_oe  <= 1'b0;
                     end
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
               ST_HI: begin
                  if (w_edge) begin
                     r_hi    <= w_nib_val;
                     r_state <= ST_LO;
                     if (r_nib_oe) begin
                        r_nib_out <= f_rev4(r_shadow[3:0]);
                     end else begin
                        r_nib_out <= 4'd0;
                     end
                  end else if (w_tmo_hit) begin
                     r_state   <= ST_IDLE;
                     r_nib_out <= 4'd0;
                     r_nib_oe  <= 1'b0;
                     r_busy    <= 1'b0;
                     r_err     <= 1'b1;
                  end else begin
                     r_state <= ST_HI;
                  end
               end
               ST_LO: begin
                  if (w_edge) begin
                     r_state   <= ST_IDLE;
                     r_nib_out <= 4'd0;
                     r_nib_oe  <= 1'b0;
                     r_busy    <= 1'b0;
                     if (r_wr && !r_bad) begin
                        r_wr_d  <= {r_hi, w_nib_val};
                        r_rd_we <= (r_sel == 2'd2);
                        r_rc_we <= (r_sel == 2'd3);
                     end else begin
                        r_wr_d <= r_wr_d;
                     end
                  end else if (w_tmo_hit) begin
                     r_state   <= ST_IDLE;
                     r_nib_out <= 4'd0;
                     r_nib_oe  <= 1'b0;
                     r_busy    <= 1'b0;
                     r_err     <= 1'b1;
                  end else begin
                     r_state <= ST_LO;
                  end
               end
               default: begin
                  r_state   <= ST_IDLE;
                  r_nib_out <= 4'd0;
                  r_nib_oe  <= 1'b0;
                  r_busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign nib_out = r_nib_out;
   assign nib_oe  = r_nib_oe;
   assign wr_d    = r_wr_d;
   assign rd_we   = r_rd_we;
   assign rc_we   = r_rc_we;
   assign busy    = r_busy;
   assign err     = r_err;

endmodule

// File: tb/tb_tipi_nib_sequencer.sv
// Scoreboard bench for tipi_nib_sequencer: per-strobe snapshots and strobe/err events.
module tb_tipi_nib_sequencer;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       r_clk = 1'b0;
   logic       r_nibrst = 1'b0;
   logic [3:0] nib_in = 4'd0;
   logic [3:0] nib_out;
   logic       nib_oe;
   logic [7:0] td_q = 8'd0;
   logic [7:0] tc_q = 8'd0;
   logic [7:0] rd_q = 8'd0;
   logic [7:0] rc_q = 8'd0;
   logic [7:0] wr_d;
   logic       rd_we;
   logic       rc_we;
   logic       busy;
   logic       err;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic       busy;
      logic       oe;
      logic [3:0] out;
   } snap_t;

   typedef struct packed {
      logic       rd;
      logic       rc;
      logic       er;
      logic [7:0] d;
   } evt_t;

   snap_t q_snap[$];
   evt_t  q_evt[$];
   logic [7:0] last_wr = 8'd0;
   bit         done = 1'b0;

   tipi_nib_sequencer #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .r_clk(r_clk), .r_nibrst(r_nibrst),
      .nib_in(nib_in), .nib_out(nib_out), .nib_oe(nib_oe),
      .td_q(td_q), .tc_q(tc_q), .rd_q(rd_q), .rc_q(rc_q),
      .wr_d(wr_d), .rd_we(rd_we), .rc_we(rc_we), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] pin(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic exp_snap(input logic b, input logic oe, input logic [3:0] val);
      snap_t s;
      s.busy = b;
      s.oe   = oe;
      s.out  = oe ? pin(val) : 4'd0;
      q_snap.push_back(s);
   endtask

   task automatic exp_evt(input logic rd, input logic rc, input logic er, input logic [7:0] d);
      evt_t e;
      e.rd = rd; e.rc = rc; e.er = er; e.d = d;
      q_evt.push_back(e);
   endtask

   task automatic send(input logic [3:0] v);
      @(negedge clk);
      nib_in = pin(v);
      r_clk  = 1'b1;
      repeat (4) @(negedge clk);
      r_clk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Snapshot monitor: SYNC+1 clocks after each pin strobe, compare state outputs.
   initial begin
      snap_t s;
      snap_t a;
      forever begin
         @(posedge r_clk);
         repeat (SYNC + 1) @(posedge clk);
         @(negedge clk);
         a = {busy, nib_oe, nib_out};
         if (q_snap.size() == 0) begin
            check("snap_unexpected", 32'(a), 32'hFFFF_FFFF);
         end else begin
            s = q_snap.pop_front();
            check("snap", 32'(a), 32'(s));
         end
      end
   end

   // Event monitor: every write strobe or err pulse must match a queued expectation.
   initial begin
      evt_t e;
      evt_t a;
      forever begin
         @(negedge clk);
         if (rd_we || rc_we || err) begin
            a = {rd_we, rc_we, err, wr_d};
            if (q_evt.size() == 0) begin
               check("evt_unexpected", 32'(a), 32'hFFFF_FFFF);
            end else begin
               e = q_evt.pop_front();
               check("evt", 32'(a), 32'(e));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with a strobe inside it, which must be ignored.
      repeat (2) @(negedge clk);
      exp_snap(1'b0, 1'b0, 4'd0);
      send(4'h0);
      check("rst_nib_out", 32'(nib_out), 32'd0);
      check("rst_nib_oe",  32'(nib_oe),  32'd0);
      check("rst_wr_d",    32'(wr_d),    32'd0);
      check("rst_we",      32'({rd_we, rc_we}), 32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_err",     32'(err),     32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);

      // Read TD = AA.
      td_q = 8'hAA; tc_q = 8'h55; rd_q = 8'h12; rc_q = 8'h34;
      exp_snap(1'b1, 1'b1, 4'hA); send(4'h0);
      exp_snap(1'b1, 1'b1, 4'hA); send(4'h0);
      exp_snap(1'b0, 1'b0, 4'h0); send(4'h0);

      // Read TC with the latch changing after the command: snapshot holds 55.
      exp_snap(1'b1, 1'b1, 4'h5); send(4'h1);
      tc_q = 8'hFF;
      exp_snap(1'b1, 1'b1, 4'h5); send(4'h0);
      exp_snap(1'b0, 1'b0, 4'h0); send(4'h0);

      // Read RC back = 34, distinct nibbles.
      exp_snap(1'b1, 1'b1, 4'h3); send(4'h3);
      exp_snap(1'b1, 1'b1, 4'h4); send(4'h0);
      exp_snap(1'b0, 1'b0, 4'h0); send(4'h0);

      // Write RD = 3C.
      exp_snap(1'b1, 1'b0, 4'h0); send(4'h6);
      exp_snap(1'b1, 1'b0, 4'h0); send(4'h3);
      last_wr = 8'h3C;
      exp_evt(1'b1, 1'b0, 1'b0, last_wr);
      exp_snap(1'b0, 1'b0, 4'h0); send(4'hC);

      // Write RC = F0.
      exp_snap(1'b1, 1'b0, 4'h0); send(4'h7);
      exp_snap(1'b1, 1'b0, 4'h0); send(4'hF);
      last_wr = 8'hF0;
      exp_evt(1'b0, 1'b1, 1'b0, last_wr);
      exp_snap(1'b0, 1'b0, 4'h0); send(4'h0);

      // Illegal: write TD, then reserved bit set.
      exp_evt(1'b0, 1'b0, 1'b1, last_wr);
      exp_snap(1'b1, 1'b0, 4'h0); send(4'h4);
      exp_snap(1'b1, 1'b0, 4'h0); send(4'h9);
      exp_snap(1'b0, 1'b0, 4'h0); send(4'h9);
      exp_evt(1'b0, 1'b0, 1'b1, last_wr);
      exp_snap(1'b1, 1'b0, 4'h0); send(4'h8);
      exp_snap(1'b1, 1'b0, 4'h0); send(4'h1);
      exp_snap(1'b0, 1'b0, 4'h0); send(4'h2);

      // Restart after the HI nibble of a write: no strobe, edges ignored while high.
      exp_snap(1'b1, 1'b0, 4'h0); send(4'h6);
      exp_snap(1'b1, 1'b0, 4'h0); send(4'h3);
      r_nibrst = 1'b1;
      repeat (6) @(negedge clk);
      check("nibrst_busy", 32'(busy), 32'd0);
      exp_snap(1'b0, 1'b0, 4'h0); send(4'h0);
      r_nibrst = 1'b0;
      repeat (6) @(negedge clk);

      // Reset mid-transfer, then a clean read of TD = C3.
      exp_snap(1'b1, 1'b0, 4'h0); send(4'h7);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      last_wr = 8'h00;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_wr_d", 32'(wr_d), 32'd0);
      repeat (4) @(negedge clk);
      td_q = 8'hC3;
      exp_snap(1'b1, 1'b1, 4'hC); send(4'h0);
      exp_snap(1'b1, 1'b1, 4'h3); send(4'h0);
      exp_snap(1'b0, 1'b0, 4'h0); send(4'h0);

`ifdef TIPI_NIB_TIMEOUT_EN
      // Stall after the command: abort with err after 16 idle cycles.
      exp_evt(1'b0, 1'b0, 1'b1, last_wr);
      exp_snap(1'b1, 1'b0, 4'h0); send(4'h6);
      repeat (30) @(negedge clk);
      check("tmo_busy", 32'(busy), 32'd0);
`endif

      repeat (10) @(negedge clk);
      check("snap_queue_empty", 32'(q_snap.size()), 32'd0);
      check("evt_queue_empty",  32'(q_evt.size()),  32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
